countdown_ctrl: RTL and testbench

- Control stage directly upstream of the down-counter.
- Turns debounced single-cycle key pulses into the counter's `cnt_inc`/`cnt_dec`/`cnt_down`/`start_flag`/`reset_flag` strobes.
- Generates the 1 Hz countdown tick and the edit-field blink mask.
- Watches the counter's BCD `Data` word to detect 00:00:00 and raise the alarm.

---
 rtl/countdown_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// Control stage for the countdown timer: turns key pulses into counter strobes,
// generates the countdown tick and edit blink mask, and raises the expiry alarm.
module countdown_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int BLINK_DIV   = 12_500_000,
  parameter int ALARM_TICKS = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_sel,
  input  logic        i_key_up,
  input  logic        i_key_down,
  input  logic        i_key_start,
  input  logic        i_key_clr,
  input  logic [31:0] i_data,
  output logic [2:0]  o_cnt_inc,
  output logic [2:0]  o_cnt_dec,
  output logic        o_cnt_down,
  output logic        o_start_flag,
  output logic        o_reset_flag,
  output logic [2:0]  o_blink_mask,
  output logic        o_alarm,
  output logic [1:0]  o_state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_QUAL = PW'(3);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [AW-1:0] ATICK_MAX = AW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sel;
  logic [PW-1:0]   r_presc;
  logic [AW-1:0]   r_atick;
  logic [BW-1:0]   r_blinkCnt;
  logic            r_phase;

  logic            w_zero;
  logic            w_anyKey;
  logic            w_upDown;
  logic            w_tick;
  logic            w_qual;
  logic            w_alarmDone;
  logic            w_blinkWrap;
  logic            w_phaseNext;
  logic [1:0]      w_selInc;
  logic [2:0]      w_maskCur;
  logic [2:0]      w_maskInc;
  logic            w_unused_sep;

  function automatic logic [2:0] onehot(input logic [1:0] sel);
    return 3'b001 << sel;
  endfunction

  assign w_zero      = (i_data[31:24] == 8'd0) && (i_data[19:12] == 8'd0) && (i_data[7:0] == 8'd0);
  assign w_unused_sep = ^{i_data[23:20], i_data[11:8]};
  assign w_anyKey    = i_key_sel | i_key_up | i_key_down | i_key_start | i_key_clr;
  assign w_upDown    = i_key_up ^ i_key_down;
  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_qual      = (r_presc >= PRESC_QUAL);
  assign w_alarmDone = (r_atick == ATICK_MAX);
  assign w_blinkWrap = (r_blinkCnt == BLINK_MAX);
  assign w_phaseNext = w_blinkWrap ? ~r_phase : r_phase;
  assign w_selInc    = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
  assign w_maskCur   = w_phaseNext ? onehot(r_sel) : 3'b000;
  assign w_maskInc   = w_phaseNext ? onehot(w_selInc) : 3'b000;
  assign o_state     = r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_blinkWrap) begin
      r_blinkCnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_blinkCnt <= r_blinkCnt + 1'b1;
    end
  end

  // The mask is built from next-cycle phase/sel so it lines up with the state it is shown in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_SET;
      r_sel        <= 2'd0;
      r_presc      <= '0;
      r_atick      <= '0;
      o_cnt_inc    <= 3'b000;
      o_cnt_dec    <= 3'b000;
      o_cnt_down   <= 1'b0;
      o_start_flag <= 1'b0;
      o_reset_flag <= 1'b0;
      o_blink_mask <= 3'b000;
      o_alarm      <= 1'b0;
    end else begin
      o_cnt_inc    <= 3'b000;
      o_cnt_dec    <= 3'b000;
      o_cnt_down   <= 1'b0;
      o_start_flag <= 1'b0;
      o_reset_flag <= 1'b0;
      o_blink_mask <= 3'b000;
      case (r_state)
        ST_SET: begin
          o_blink_mask <= w_maskCur;
          if (i_key_clr) begin
            o_reset_flag <= 1'b1;
          end else if (i_key_start && !w_zero) begin
            o_start_flag <= 1'b1;
            o_blink_mask <= 3'b000;
            r_presc      <= '0;
            r_state      <= ST_RUN;
          end else if (i_key_sel) begin
            r_sel        <= w_selInc;
            o_blink_mask <= w_maskInc;
          end else if (w_upDown) begin
            if (i_key_up) o_cnt_inc <= onehot(r_sel);
            else          o_cnt_dec <= onehot(r_sel);
          end
        end
        ST_RUN: begin
          if (i_key_clr) begin
            o_reset_flag <= 1'b1;
            o_blink_mask <= w_maskCur;
            r_presc      <= '0;
            r_state      <= ST_SET;
          end else if (i_key_start) begin
            r_state <= ST_PAUSE;
          end else if (w_qual && w_zero) begin
            o_alarm <= 1'b1;
            r_presc <= '0;
            r_atick <= '0;
            r_state <= ST_ALARM;
          end else if (w_tick) begin
            o_cnt_down <= 1'b1;
            r_presc    <= '0;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (i_key_clr) begin
            o_reset_flag <= 1'b1;
            o_blink_mask <= w_maskCur;
            r_presc      <= '0;
            r_state      <= ST_SET;
          end else if (i_key_start) begin
            r_state <= ST_RUN;
          end
        end
        ST_ALARM: begin
          if (w_anyKey || (w_tick && w_alarmDone)) begin
            o_reset_flag <= 1'b1;
            o_alarm      <= 1'b0;
            o_blink_mask <= w_maskCur;
            r_presc      <= '0;
            r_atick      <= '0;
            r_state      <= ST_SET;
          end else if (w_tick) begin
            r_presc <= '0;
            r_atick <= r_atick + 1'b1;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        default: r_state <= ST_SET;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios plus random keys, checked every cycle
// against a cycle-counting reference model driving a model of the down-counter.
module tb_countdown_ctrl;
  localparam int TICK_DIV    = 10;
  localparam int BLINK_DIV   = 4;
  localparam int ALARM_TICKS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        keySel = 1'b0, keyUp = 1'b0, keyDown = 1'b0, keyStart = 1'b0, keyClr = 1'b0;
  logic [31:0] data = 32'd0;
  logic [2:0]  cntInc, cntDec, blinkMask;
  logic        cntDown, startFlag, resetFlag, alarm;
  logic [1:0]  state;

  int checkCount = 0;
  int passCount  = 0;

  int mMode, mSel, mRunCycles, mAlarmCycles, mEdges;
  logic [2:0] eInc, eDec, eMask;
  logic       eDown, eStart, eReset, eAlarm;

  int cTime = 0, cPreset = 0;
  logic [2:0] pInc, pDec;
  logic       pDown, pStart, pReset;

  countdown_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .ALARM_TICKS(ALARM_TICKS)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_key_sel(keySel), .i_key_up(keyUp), .i_key_down(keyDown),
    .i_key_start(keyStart), .i_key_clr(keyClr), .i_data(data),
    .o_cnt_inc(cntInc), .o_cnt_dec(cntDec), .o_cnt_down(cntDown),
    .o_start_flag(startFlag), .o_reset_flag(resetFlag), .o_blink_mask(blinkMask),
    .o_alarm(alarm), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
  endtask

  function automatic logic [31:0] encode(input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {4'(s % 10), 4'(s / 10), 4'hA, 4'(m % 10), 4'(m / 10), 4'hA, 4'(h % 10), 4'(h / 10)};
  endfunction

  function automatic int fieldAdj(input int t, input int f, input int d);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    if (f == 0) s = (s + d + 60) % 60;
    else if (f == 1) m = (m + d + 60) % 60;
    else h = (h + d + 24) % 24;
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic resetModel();
    mMode = 0; mSel = 0; mRunCycles = 0; mAlarmCycles = 0; mEdges = 0;
    eInc = 0; eDec = 0; eMask = 0; eDown = 0; eStart = 0; eReset = 0; eAlarm = 0;
    pInc = 0; pDec = 0; pDown = 0; pStart = 0; pReset = 0;
  endtask

  // k = {clr, start, sel, up, down}; uses the time value the DUT saw before this edge
  task automatic modelEdge(input logic [4:0] k);
    bit z;
    int p;
    z = (cTime == 0);
    eInc = 0; eDec = 0; eDown = 0; eStart = 0; eReset = 0;
    mEdges++;
    case (mMode)
      0: begin
        if (k[4]) eReset = 1;
        else if (k[3] && !z) begin eStart = 1; mMode = 1; mRunCycles = 0; end
        else if (k[2]) mSel = (mSel + 1) % 3;
        else if (k[1] != k[0]) begin
          if (k[1]) eInc = 3'(1 << mSel);
          else      eDec = 3'(1 << mSel);
        end
      end
      1: begin
        p = mRunCycles % TICK_DIV;
        if (k[4]) begin eReset = 1; mMode = 0; mRunCycles = 0; end
        else if (k[3]) mMode = 2;
        else if (p >= 3 && z) begin mMode = 3; mAlarmCycles = 0; mRunCycles = 0; end
        else begin
          if (p == TICK_DIV - 1) eDown = 1;
          mRunCycles++;
        end
      end
      2: begin
        if (k[4]) begin eReset = 1; mMode = 0; mRunCycles = 0; end
        else if (k[3]) mMode = 1;
      end
      default: begin
        if (k != 0) begin eReset = 1; mMode = 0; end
        else begin
          mAlarmCycles++;
          if (mAlarmCycles == ALARM_TICKS * TICK_DIV) begin eReset = 1; mMode = 0; end
        end
      end
    endcase
    eMask  = (mMode == 0 && ((mEdges / BLINK_DIV) % 2 == 1)) ? 3'(1 << mSel) : 3'b000;
    eAlarm = (mMode == 3);
  endtask

  // Down-counter reacts one edge after a strobe appears
  task automatic counterEdge();
    if (pReset) cTime = cPreset;
    else if (pStart) cPreset = cTime;
    else if (pDown) cTime = (cTime + 86399) % 86400;
    for (int f = 0; f < 3; f++) begin
      if (pInc[f]) cTime = fieldAdj(cTime, f, 1);
      if (pDec[f]) cTime = fieldAdj(cTime, f, -1);
    end
    pInc = eInc; pDec = eDec; pDown = eDown; pStart = eStart; pReset = eReset;
  endtask

  task automatic compareAll();
    checkOutput("cnt_inc", 32'(cntInc), 32'(eInc));
    checkOutput("cnt_dec", 32'(cntDec), 32'(eDec));
    checkOutput("cnt_down", 32'(cntDown), 32'(eDown));
    checkOutput("start_flag", 32'(startFlag), 32'(eStart));
    checkOutput("reset_flag", 32'(resetFlag), 32'(eReset));
    checkOutput("blink_mask", 32'(blinkMask), 32'(eMask));
    checkOutput("alarm", 32'(alarm), 32'(eAlarm));
    checkOutput("state", 32'(state), 32'(mMode));
  endtask

  task automatic applyStimulus(input logic [4:0] k);
    {keyClr, keyStart, keySel, keyUp, keyDown} = k;
    data = encode(cTime);
    @(posedge clk); #1;
    modelEdge(k);
    counterEdge();
    compareAll();
    {keyClr, keyStart, keySel, keyUp, keyDown} = 5'b0;
    data = encode(cTime);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(5'b0);
  endtask

  // Reset lands between edges; outputs must clear before any clock edge
  task automatic doReset();
    #2;
    rst = 1'b1;
    {keyClr, keyStart, keySel, keyUp, keyDown} = 5'b0;
    #1;
    resetModel();
    compareAll();
    @(posedge clk); @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    compareAll();
  endtask

  localparam logic [4:0] K_NONE = 5'b00000, K_DOWN = 5'b00001, K_UP = 5'b00010,
                         K_SEL = 5'b00100, K_START = 5'b01000, K_CLR = 5'b10000;

  initial begin
    resetModel();
    doReset();

    $display("[TB] edit field selection and blink");
    applyStimulus(K_SEL); idle(2);
    applyStimulus(K_SEL); idle(2);
    for (int i = 0; i < 3; i++) begin applyStimulus(K_UP); idle(2); end
    applyStimulus(K_DOWN); idle(12);
    applyStimulus(K_UP | K_DOWN); idle(2);

    $display("[TB] start, countdown and expiry");
    applyStimulus(K_SEL); idle(1);
    cTime = 3; data = encode(cTime);
    applyStimulus(K_START);
    idle(70);
    checkOutput("state after alarm exit", 32'(state), 32'd0);

    $display("[TB] pause and resume");
    cTime = 30; data = encode(cTime);
    applyStimulus(K_START);
    idle(12);
    for (int i = 0; i < 2 * TICK_DIV && (mRunCycles % TICK_DIV) != 6; i++) applyStimulus(K_NONE);
    applyStimulus(K_START);
    idle(50);
    checkOutput("state while paused", 32'(state), 32'd2);
    applyStimulus(K_START);
    idle(15);

    $display("[TB] key priority and zero start");
    applyStimulus(K_CLR | K_START);
    checkOutput("state after clr+start", 32'(state), 32'd0);
    idle(2);
    cTime = 0; data = encode(cTime);
    applyStimulus(K_START); idle(2);
    checkOutput("state after zero start", 32'(state), 32'd0);

    $display("[TB] async reset mid-run");
    cTime = 20; data = encode(cTime);
    applyStimulus(K_START);
    idle(15);
    doReset();
    idle(3);

    $display("[TB] random keys");
    cTime = 5; data = encode(cTime);
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      case (r)
        0:       applyStimulus(K_SEL);
        1, 2:    applyStimulus(K_UP);
        3:       applyStimulus(K_DOWN);
        4, 5:    applyStimulus(K_START);
        6:       applyStimulus(K_CLR);
        7:       applyStimulus(K_UP | K_DOWN);
        default: applyStimulus(K_NONE);
      endcase
      if (mMode == 0 && cTime > 40 && $urandom_range(0, 3) == 0) begin
        cTime = $urandom_range(0, 6);
        data  = encode(cTime);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
